// File: rtl/md_sched_pkg.sv
// md_sched_pkg: op and state codes shared by the multiply/divide sequencer, D-stage decode and hazard.
package md_sched_pkg;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;
  typedef enum logic {MD_IDLE = 1'b0, MD_RUN = 1'b1} md_state_e;
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction
endpackage

// File: rtl/md_sched_alu.sv
// md_alu: combinational multiply/divide datapath producing {hi,lo} and a divide-by-zero flag.
module md_alu
  import md_sched_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        div_zero_o
);
  logic signed [63:0] smul;
  logic [63:0] umul;
  logic signed [31:0] sq, sr;
  logic [31:0] uq, ur;
  logic bz, ovf;
  assign smul = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign umul = {32'd0, a_i} * {32'd0, b_i};
  assign bz = (b_i == 32'd0);
  // most-negative / -1 overflows the signed quotient; pin it to the defined result
  assign ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
  assign sq = (bz || ovf) ? $signed(a_i) : $signed(a_i) / $signed(b_i);
  assign sr = (bz || ovf) ? 32'sd0 : $signed(a_i) % $signed(b_i);
  assign uq = bz ? 32'd0 : a_i / b_i;
  assign ur = bz ? 32'd0 : a_i % b_i;
  assign div_zero_o = bz && ((op_i == MD_DIV) || (op_i == MD_DIVU));
  always_comb begin
    res_o = (op_i == MD_MULT)  ? smul :
            (op_i == MD_MULTU) ? umul :
            (op_i == MD_DIV)   ? {sr, sq} :
            (op_i == MD_DIVU)  ? {ur, uq} : 64'd0;
  end
endmodule

// File: rtl/md_sched.sv
// md_sched: sequences the shared HI/LO multiply/divide unit, holding it busy for a fixed latency
// before committing the pending 64-bit result.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        START,
  input  logic [2:0]  MD_OP,
  input  logic [31:0] SRC_A,
  input  logic [31:0] SRC_B,
  input  logic        FLUSH,
  output logic        BUSY,
  output logic        MD_STALL,
  output logic        DONE,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);
  md_state_e state_q;
  logic [3:0] cnt_q;
  logic [63:0] pend_q, alu_res;
  logic [31:0] hi_q, lo_q;
  logic busy_q, done_q, dz_q, alu_dz, accept, muldiv, is_mul;
  md_alu u_alu (.op_i(MD_OP), .a_i(SRC_A), .b_i(SRC_B), .res_o(alu_res), .div_zero_o(alu_dz));
  assign muldiv = is_muldiv(MD_OP);
  assign is_mul = (MD_OP == MD_MULT) || (MD_OP == MD_MULTU);
  assign accept = START & ~FLUSH & (state_q == MD_IDLE);
  assign MD_STALL = (START & ~FLUSH & muldiv) | busy_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign HI = hi_q;
  assign LO = lo_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: if (accept) begin
          if (muldiv) begin
            pend_q  <= alu_res;
            dz_q    <= alu_dz;
            cnt_q   <= is_mul ? MUL_N : DIV_N;
            busy_q  <= 1'b1;
            state_q <= MD_RUN;
          end
          if (MD_OP == MD_MTHI) hi_q <= SRC_A;
          if (MD_OP == MD_MTLO) lo_q <= SRC_A;
        end
        MD_RUN: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (!dz_q) {hi_q, lo_q} <= pend_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= MD_IDLE;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed checks of md_sched latency, arithmetic, MTHI/MTLO, flush and reset behaviour.
module tb_md_sched;
  import md_sched_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, START = 1'b0, FLUSH = 1'b0;
  logic [2:0] MD_OP = 3'd0;
  logic [31:0] SRC_A = 32'd0, SRC_B = 32'd0;
  logic BUSY, MD_STALL, DONE;
  logic [31:0] HI, LO;
  int checks = 0, fails = 0, illegal = 0;

  md_sched dut (
    .clk(clk), .reset_n(reset_n), .START(START), .MD_OP(MD_OP), .SRC_A(SRC_A), .SRC_B(SRC_B),
    .FLUSH(FLUSH), .BUSY(BUSY), .MD_STALL(MD_STALL), .DONE(DONE), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // hazard must never let a new op reach the unit while it is running
  always @(negedge clk) begin
    #2;
    assert (!(START && !FLUSH && BUSY)) else illegal++;
  end

  // Issues an op in the current cycle, scrambles operands during RUN, checks busy window and commit.
  task automatic md_run(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] ehi, input logic [31:0] elo, input int flush_at);
    START = 1'b1; MD_OP = op; SRC_A = a; SRC_B = b;
    #1;
    checks++;
    if (MD_STALL !== 1'b1) begin fails++; $display("FAIL %s_stall_accept: got %b want 1", nm, MD_STALL); end
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      START = 1'b0; FLUSH = (c == flush_at); SRC_A = ~a; SRC_B = b + 32'd1;
      #1;
      checks++;
      if ({BUSY, DONE, MD_STALL} !== 3'b101) begin
        fails++; $display("FAIL %s_busy c%0d: got busy/done/stall %b want 101", nm, c, {BUSY, DONE, MD_STALL});
      end
    end
    @(negedge clk);
    FLUSH = 1'b0;
    #1;
    checks++;
    if ({BUSY, DONE} !== 2'b01) begin fails++; $display("FAIL %s_done: got busy/done %b want 01", nm, {BUSY, DONE}); end
    checks++;
    if ({HI, LO} !== {ehi, elo}) begin fails++; $display("FAIL %s_result: got %h_%h want %h_%h", nm, HI, LO, ehi, elo); end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({BUSY, DONE, HI, LO, MD_STALL} !== 67'd0) begin
      fails++; $display("FAIL reset_state: got %b %b %h %h %b want all 0", BUSY, DONE, HI, LO, MD_STALL);
    end
    START = 1'b1; MD_OP = MD_MULT; #1;
    checks++;
    if (MD_STALL !== 1'b1) begin fails++; $display("FAIL reset_stall_eq: got %b want 1", MD_STALL); end
    @(negedge clk);
    START = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_mt();
    @(negedge clk);
    START = 1'b1; FLUSH = 1'b1; MD_OP = MD_MTLO; SRC_A = 32'h1234_5678; #1;
    checks++;
    if (MD_STALL !== 1'b0) begin fails++; $display("FAIL mtlo_stall: got %b want 0", MD_STALL); end
    @(negedge clk);
    FLUSH = 1'b0; #1;
    checks++;
    if (LO !== 32'd0) begin fails++; $display("FAIL mtlo_flushed: got %h want 00000000", LO); end
    @(negedge clk);
    START = 1'b1; MD_OP = MD_MTHI; SRC_A = 32'hCAFE_F00D; #1;
    checks++;
    if ({BUSY, LO} !== {1'b0, 32'h1234_5678}) begin fails++; $display("FAIL mtlo_write: got busy %b lo %h want 0 12345678", BUSY, LO); end
    @(negedge clk);
    START = 1'b0; #1;
    checks++;
    if ({BUSY, HI, LO} !== {1'b0, 32'hCAFE_F00D, 32'h1234_5678}) begin
      fails++; $display("FAIL mthi_write: got busy %b hi %h lo %h want 0 cafef00d 12345678", BUSY, HI, LO);
    end
  endtask

  task automatic test_mult();
    @(negedge clk);
    md_run("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, -1);
    @(negedge clk); #1;
    checks++;
    if (DONE !== 1'b0) begin fails++; $display("FAIL mult_done_pulse: got %b want 0", DONE); end
    md_run("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, -1);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    md_run("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    md_run("divu_zero", MD_DIVU, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    @(negedge clk);
    md_run("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, -1);
  endtask

  task automatic test_flush_run();
    @(negedge clk);
    md_run("div_flush", MD_DIV, 32'd100, 32'd7, 10, 32'd2, 32'd14, 3);
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk);
    START = 1'b1; MD_OP = MD_DIV; SRC_A = 32'd50; SRC_B = 32'd3;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      START = 1'b0;
    end
    reset_n = 1'b0; #1;
    checks++;
    if ({BUSY, DONE, HI, LO, MD_STALL} !== 67'd0) begin
      fails++; $display("FAIL reset_mid: got %b %b %h %h %b want all 0", BUSY, DONE, HI, LO, MD_STALL);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk); #1;
      if (DONE === 1'b1 || BUSY === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin fails++; $display("FAIL reset_mid_no_done: got %0d active cycles want 0", dones); end
  endtask

  initial begin
    test_reset();
    test_mt();
    test_mult();
    test_back_to_back();
    test_flush_run();
    test_reset_mid();
    checks++;
    if (illegal !== 0) begin fails++; $display("FAIL start_in_run: got %0d want 0", illegal); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/md_sched.md
# md_sched

Sequencer for the shared HI/LO multiply/divide resource in the E stage of the five-stage pipeline. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request per cycle from the E stage. It holds the unit busy for a fixed multiply or divide latency, then commits the 64-bit result to HI/LO. It reports occupancy to `hazard`, which stalls any HI/LO-dependent instruction in D.

## Interface
- `MUL_CYCLES`, default 5: busy cycles for MULT/MULTU; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `START`  in  1  E-stage instruction is a multiply/divide-unit op.
- `MD_OP`  in  3  operation code (see Structure).
- `SRC_A`  in  32  forwarded rs value.
- `SRC_B`  in  32  forwarded rt value.
- `FLUSH`  in  1  E-stage instruction is being cancelled (exception/interrupt); suppresses START this cycle.
- `BUSY`  out  1  operation in flight (registered).
- `MD_STALL`  out  1  `(START & ~FLUSH & MD_OP is MULT/MULTU/DIV/DIVU) | BUSY`; combinational, to `hazard`.
- `DONE`  out  1  one-cycle pulse, the cycle HI/LO first show a committed result.
- `HI`  out  32  architectural HI.
- `LO`  out  32  architectural LO.

## Operation
- Two states, IDLE and RUN, plus a 4-bit down-counter `cnt` and 64-bit pending register `{p_hi,p_lo}`.
- IDLE, accepted START (START & ~FLUSH):
  - MULT/MULTU/DIV/DIVU: latch the `md_alu` result into pending, load `cnt` with MUL_CYCLES or DIV_CYCLES, then go to RUN.
  - MTHI writes HI ← SRC_A at this edge and stays IDLE; MTLO likewise writes LO.
  - Undefined MD_OP: ignored.
- RUN: `cnt` decrements each edge. The edge at which `cnt==1` commits HI←p_hi and LO←p_lo, sets `cnt` to 0 and returns to IDLE.
- Arithmetic:
  - MULT: signed 32×32→64, {HI,LO}.
  - MULTU: unsigned 32×32→64, {HI,LO}.
  - DIV/DIVU: LO = quotient, truncated toward zero; HI = remainder, sign follows dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero: full DIV_CYCLES latency still elapses, DONE still pulses, HI/LO remain unchanged.
- START while in RUN is illegal, because `hazard` guarantees it never occurs. The block ignores it; the bench asserts on it.
- FLUSH during RUN does not abort: an op already accepted is architecturally committed.
- Operands are sampled only at the accept edge; later changes on SRC_A/SRC_B have no effect.

## Timing
- Reset (reset_n low, asynchronous): state=IDLE, cnt=0, BUSY=0, DONE=0, HI=0, LO=0, pending=0. MD_STALL follows its equation (0 unless START is high).
- Accept at cycle t:
  - MD_STALL is high in cycle t (combinational).
  - BUSY is high in cycles t+1 .. t+N, where N = MUL_CYCLES or DIV_CYCLES.
  - HI/LO change at the edge ending cycle t+N and are new in cycle t+N+1. DONE is high in cycle t+N+1 only; BUSY is low in that cycle.
- Back-to-back: a new START may be accepted in cycle t+N+1 (IDLE). HI/LO read in that cycle already reflect the previous op.
- MTHI/MTLO: the value is visible in the cycle after the accept edge. There is zero busy time.
- Reset asserted mid-RUN: immediate return to reset values. The pending result is discarded and no DONE is produced.

## Structure
- Constants go in the shared `head.v` header: MD_OP codes `MD_NONE=0`, `MD_MULT=1`, `MD_MULTU=2`, `MD_DIV=3`, `MD_DIVU=4`, `MD_MTHI=5`, `MD_MTLO=6`, and state codes `MD_IDLE`, `MD_RUN`. The D-stage decoder and `hazard` share these codes.
- One sub-module, `md_alu`: purely combinational, MD_OP/SRC_A/SRC_B → 64-bit {hi,lo} plus a `div_zero` flag. Keeping it separate allows a later iterative divider to replace it without touching the sequencing.
- Sequencing, the counter, pending/HI/LO registers and MD_STALL stay in `md_sched`.

## Test plan
- MULT A=0xFFFFFFFE (-2), B=3 at cycle 0 → BUSY in cycles 1–5; cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA, DONE=1.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=-7, B=2 → BUSY in cycles 1–10; cycle 11: LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU 7/0 issued in cycle 11 → 10 busy cycles, DONE pulses, HI/LO are unchanged.
- MTLO 0x12345678 with FLUSH=1 → LO stays 0. The same op with FLUSH=0 → LO=0x12345678 in the next cycle, and BUSY never rises.
- DIV started, then FLUSH=1 in cycle 3 → result still commits in cycle 11. A separate run with reset_n pulsed low in cycle 4 → all outputs are 0 immediately and no DONE appears.
